// File: rtl/pipe_pkg.sv
// Shared types and constants for the skid-buffered pipeline stage.
package pipe_pkg;

  // Slot occupancy of the stage; encodes how many entries are held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  // Bit positions inside the control vector.
  localparam int CTRL_DM_WE    = 0;
  localparam int CTRL_NEXT_PC  = 1;
  localparam int CTRL_RF_D_SEL = 2;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry register: loads all fields together when enabled.
module pipe_slot #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] d_alu_res,
  input  logic [DATA_W-1:0] d_store_data,
  input  logic [ADDR_W-1:0] d_dm_addr,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic [DATA_W-1:0] q_alu_res,
  output logic [DATA_W-1:0] q_store_data,
  output logic [ADDR_W-1:0] q_dm_addr,
  output logic [CTRL_W-1:0] q_ctrl
);

  // Capture the whole entry on load; hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_alu_res    <= '0;
      q_store_data <= '0;
      q_dm_addr    <= '0;
      q_ctrl       <= '0;
    end else if (load) begin
      q_alu_res    <= d_alu_res;
      q_store_data <= d_store_data;
      q_dm_addr    <= d_dm_addr;
      q_ctrl       <= d_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-slot skid-buffered pipeline register between execute and memory.
//
//   state | meaning
//   ------+--------------------------------------------------
//   EMPTY | no entry held; accepting
//   FULL  | main slot holds the head entry; accepting
//   SKID  | main holds head, skid holds the next; not accepting
//
// in_ready decodes only the state register so it never depends on out_ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int CTRL_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [ADDR_W-1:0] in_dm_addr,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [DATA_W-1:0] out_store_data,
  output logic [ADDR_W-1:0] out_dm_addr,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t state_q, state_d;

  logic              in_xfer, out_xfer;
  logic              main_load, main_from_skid, skid_load;
  logic [DATA_W-1:0] main_d_alu_res, main_d_store_data;
  logic [ADDR_W-1:0] main_d_dm_addr;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic [DATA_W-1:0] skid_alu_res, skid_store_data;
  logic [ADDR_W-1:0] skid_dm_addr;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [CTRL_W-1:0] main_ctrl;

  assign in_ready  = (state_q != SKID);
  assign out_valid = (state_q != EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next state and slot load enables; flush wins over any handshake.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d   = FULL;
            main_load = 1'b1;
          end
        end
        FULL: begin
          if (in_xfer && !out_xfer) begin
            state_d   = SKID;
            skid_load = 1'b1;
          end else if (!in_xfer && out_xfer) begin
            state_d = EMPTY;
          end else if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end
        end
        SKID: begin
          if (out_xfer) begin
            state_d        = FULL;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Main slot refills from the skid slot when draining, else from upstream.
  always_comb begin
    main_d_alu_res    = main_from_skid ? skid_alu_res    : in_alu_res;
    main_d_store_data = main_from_skid ? skid_store_data : in_store_data;
    main_d_dm_addr    = main_from_skid ? skid_dm_addr    : in_dm_addr;
    main_d_ctrl       = main_from_skid ? skid_ctrl       : in_ctrl;
  end

  pipe_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) u_main (
    .clk          (clk),
    .rst          (rst),
    .load         (main_load),
    .d_alu_res    (main_d_alu_res),
    .d_store_data (main_d_store_data),
    .d_dm_addr    (main_d_dm_addr),
    .d_ctrl       (main_d_ctrl),
    .q_alu_res    (out_alu_res),
    .q_store_data (out_store_data),
    .q_dm_addr    (out_dm_addr),
    .q_ctrl       (main_ctrl)
  );

  pipe_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) u_skid (
    .clk          (clk),
    .rst          (rst),
    .load         (skid_load),
    .d_alu_res    (in_alu_res),
    .d_store_data (in_store_data),
    .d_dm_addr    (in_dm_addr),
    .d_ctrl       (in_ctrl),
    .q_alu_res    (skid_alu_res),
    .q_store_data (skid_store_data),
    .q_dm_addr    (skid_dm_addr),
    .q_ctrl       (skid_ctrl)
  );

  // A stale main slot after flush or drain must never look like a store.
  assign out_ctrl = out_valid ? main_ctrl : '0;

  // Saturating count of cycles the head entry is held back by downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios then random valid/ready,
// all checked against a queue-based model of the stage.
module tb_pipe_stage_skid;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int CTRL_W = 3;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] sd;
    logic [ADDR_W-1:0] addr;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_alu_res;
  logic [DATA_W-1:0] in_store_data;
  logic [ADDR_W-1:0] in_dm_addr;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_alu_res;
  logic [DATA_W-1:0] out_store_data;
  logic [ADDR_W-1:0] out_dm_addr;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  entry_t mq[$];
  int     m_stall = 0;

  pipe_stage_skid #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_alu_res     (in_alu_res),
    .in_store_data  (in_store_data),
    .in_dm_addr     (in_dm_addr),
    .in_ctrl        (in_ctrl),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_alu_res    (out_alu_res),
    .out_store_data (out_store_data),
    .out_dm_addr    (out_dm_addr),
    .out_ctrl       (out_ctrl),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic entry_t mk(input logic [DATA_W-1:0] v, input logic [CTRL_W-1:0] c);
    entry_t e;
    e.alu  = v;
    e.sd   = ~v;
    e.addr = v[ADDR_W-1:0] ^ 16'h5a5a;
    e.ctrl = c;
    return e;
  endfunction

  // Compare all outputs with what the model queue implies.
  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    if (mq.size() > 0) begin
      chk("out_alu_res", 64'(out_alu_res), 64'(mq[0].alu));
      chk("out_store_data", 64'(out_store_data), 64'(mq[0].sd));
      chk("out_dm_addr", 64'(out_dm_addr), 64'(mq[0].addr));
      chk("out_ctrl", 64'(out_ctrl), 64'(mq[0].ctrl));
    end else begin
      chk("ctrl_bubble", 64'(out_ctrl), 64'd0);
    end
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
  endtask

  // Drive one cycle of inputs (called just after a falling edge), advance the
  // model by the handshake rules, then check after the next rising edge.
  task automatic step(input logic v, input logic f, input logic r, input entry_t e);
    int  n;
    bit  ov, ir;
    in_valid      = v;
    flush         = f;
    out_ready     = r;
    in_alu_res    = e.alu;
    in_store_data = e.sd;
    in_dm_addr    = e.addr;
    in_ctrl       = e.ctrl;
    n  = mq.size();
    ov = (n > 0);
    ir = (n < 2);
    if (ov && !r && m_stall < CNT_MAX) m_stall++;
    if (f) begin
      mq.delete();
    end else begin
      if (ov && r) void'(mq.pop_front());
      if (v && ir) mq.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    entry_t e;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_alu_res = '0; in_store_data = '0; in_dm_addr = '0; in_ctrl = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all();
    chk("rst_alu_zero", 64'(out_alu_res), 64'd0);
    chk("rst_sd_zero", 64'(out_store_data), 64'd0);
    chk("rst_addr_zero", 64'(out_dm_addr), 64'd0);

    // Streaming: 1,2,3 flow through with one cycle latency.
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b0, 1'b1, mk(DATA_W'(i), 3'b011));
      chk("stream_out", 64'(out_alu_res), 64'(i));
    end
    chk("stream_full", 64'({out_valid, in_ready}), 64'b11);
    chk("stream_stall", 64'(stall_cnt), 64'd0);
    step(1'b0, 1'b0, 1'b1, mk('0, '0));

    // Backpressure into the skid slot, then drain in order.
    step(1'b1, 1'b0, 1'b0, mk(32'hA, 3'b001));
    step(1'b1, 1'b0, 1'b0, mk(32'hB, 3'b101));
    chk("bp_not_ready", 64'(in_ready), 64'd0);
    chk("bp_head_a", 64'(out_alu_res), 64'hA);
    step(1'b0, 1'b0, 1'b1, mk('0, '0));
    chk("bp_head_b", 64'(out_alu_res), 64'hB);
    step(1'b0, 1'b0, 1'b1, mk('0, '0));
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Flush while SKID with a concurrent input and output handshake.
    step(1'b1, 1'b0, 1'b0, mk(32'hC, 3'b001));
    step(1'b1, 1'b0, 1'b0, mk(32'hD, 3'b001));
    step(1'b1, 1'b1, 1'b1, mk(32'hE, 3'b001));
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ctrl", 64'(out_ctrl), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    step(1'b0, 1'b0, 1'b1, mk('0, '0));
    chk("flush_no_e", 64'(out_valid), 64'd0);

    // Stall counter saturates and holds.
    step(1'b1, 1'b0, 1'b0, mk(32'h5, 3'b111));
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, mk('0, '0));
    chk("stall_sat", 64'(stall_cnt), 64'(CNT_MAX));
    step(1'b0, 1'b0, 1'b0, mk('0, '0));
    chk("stall_hold", 64'(stall_cnt), 64'(CNT_MAX));

    // Async reset between edges while SKID.
    step(1'b1, 1'b0, 1'b0, mk(32'h6, 3'b001));
    chk("pre_rst_skid", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_alu", 64'(out_alu_res), 64'd0);
    chk("arst_sd", 64'(out_store_data), 64'd0);
    chk("arst_addr", 64'(out_dm_addr), 64'd0);
    chk("arst_ctrl", 64'(out_ctrl), 64'd0);
    chk("arst_stall", 64'(stall_cnt), 64'd0);
    mq.delete();
    m_stall = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all();
    chk("arst_ready", 64'(in_ready), 64'd1);
    step(1'b0, 1'b0, 1'b1, mk('0, '0));
    chk("arst_no_xfer", 64'(out_valid), 64'd0);

    // Random traffic against the queue model.
    for (int i = 0; i < 10000; i++) begin
      e.alu  = $urandom;
      e.sd   = $urandom;
      e.addr = ADDR_W'($urandom);
      e.ctrl = CTRL_W'($urandom_range(0, 7));
      step(1'($urandom_range(0, 99) < 60),
           1'($urandom_range(0, 63) == 0),
           1'($urandom_range(0, 99) < 55),
           e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
